vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator and TinyVGA PMOD driver.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA pin map, default 640x480@60 timing and pipeline payload type
package vga_pkg;
    localparam int PMOD_R1 = 0;
    localparam int PMOD_G1 = 1;
    localparam int PMOD_B1 = 2;
    localparam int PMOD_VS = 3;
    localparam int PMOD_R0 = 4;
    localparam int PMOD_G0 = 5;
    localparam int PMOD_B0 = 6;
    localparam int PMOD_HS = 7;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_ctl_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: ce-gated shift register with synchronous clear; DEPTH=0 is a plain wire
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = &{1'b0, clk, rst, ce};
        assign q = d;
    end else begin : g_sr
        logic [DEPTH-1:0][W-1:0] sr;
        // shift one stage per pixel, cleared on reset
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else if (ce) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing generator and TinyVGA PMOD driver (optional frame_cnt via VGA_FRAME_COUNTER_EN)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int PIX_LATENCY = 1,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    input  logic [5:0]    rgb_in,
    output logic [7:0]    vga_pmod
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HP      = 1'(H_SYNC_POL);
    localparam logic          VP      = 1'(V_SYNC_POL);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        PIX_LATENCY < 0 || PIX_LATENCY > 4 ||
        (H_SYNC_POL != 0 && H_SYNC_POL != 1) || (V_SYNC_POL != 0 && V_SYNC_POL != 1)) begin : g_bad_params
        $error("vga_timing_gen: illegal timing, latency or polarity parameter");
    end

    logic     x_end, y_end;
    vga_ctl_t ctl_raw, ctl_dly;
    logic [5:0] rgb;
    logic [7:0] pmod_nxt;

    assign x_end       = x == H_LAST;
    assign y_end       = y == V_LAST;
    assign active      = x < H_VIS && y < V_VIS;
    assign line_start  = x == '0;
    assign frame_start = x == '0 && y == '0;
    assign ctl_raw     = '{hs: x >= HS_BEG && x < HS_END, vs: y >= VS_BEG && y < VS_END, de: active};

    // raster counters: x runs every pixel, y steps when x wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            x <= x_end ? '0 : x + 1'b1;
            if (x_end) y <= y_end ? '0 : y + 1'b1;
        end
    end

    vga_delay_line #(.DEPTH(PIX_LATENCY), .W($bits(vga_ctl_t))) u_align (
        .clk (clk),
        .rst (rst),
        .ce  (pix_ce),
        .d   (ctl_raw),
        .q   (ctl_dly)
    );

    // blank the colour outside the visible area and drive sync at its configured level
    always_comb begin
        rgb                = ctl_dly.de ? rgb_in : 6'b0;
        pmod_nxt           = '0;
        pmod_nxt[PMOD_HS]  = ~(ctl_dly.hs ^ HP);
        pmod_nxt[PMOD_VS]  = ~(ctl_dly.vs ^ VP);
        pmod_nxt[PMOD_R1]  = rgb[5];
        pmod_nxt[PMOD_R0]  = rgb[4];
        pmod_nxt[PMOD_G1]  = rgb[3];
        pmod_nxt[PMOD_G0]  = rgb[2];
        pmod_nxt[PMOD_B1]  = rgb[1];
        pmod_nxt[PMOD_B0]  = rgb[0];
    end

    // output pin register, idle syncs and black on reset
    always_ff @(posedge clk) begin
        if (rst) vga_pmod <= {~HP, 3'b0, ~VP, 3'b0};
        else if (pix_ce) vga_pmod <= pmod_nxt;
    end

`ifdef VGA_FRAME_COUNTER_EN
    // count completed frames on the pixel where both counters wrap
    always_ff @(posedge clk) begin
        if (rst) frame_cnt <= '0;
        else if (pix_ce && x_end && y_end) frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a reduced 15x8 raster (HS x=10..12, VS y=5..6)
module tb_vga_timing_gen;
    logic       clk = 0;
    logic       rst = 1;
    logic       pix_ce = 1;
    logic [5:0] rgb_in = 6'h3F;
    logic [3:0] x, x2;
    logic [2:0] y, y2;
    logic       active, line_start, frame_start;
    logic       active2, line_start2, frame_start2;
    logic [7:0] pmod, pmod2;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] fcnt, fcnt2;
`endif
    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .PIX_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y), .active(active),
        .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in), .vga_pmod(pmod)
`ifdef VGA_FRAME_COUNTER_EN
        , .frame_cnt(fcnt)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_LATENCY(0)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x2), .y(y2), .active(active2),
        .line_start(line_start2), .frame_start(frame_start2), .rgb_in(rgb_in), .vga_pmod(pmod2)
`ifdef VGA_FRAME_COUNTER_EN
        , .frame_cnt(fcnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_fs, n_ls, n_hs, n_vs, n_rgb, n_part, n_hs2, n_vs2, first_rgb;
        logic [7:0] prev_pmod;
        logic [3:0] prev_x;
        // reset state
        step;
        step;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_active", 32'(active), 1);
        chk("rst_line_start", 32'(line_start), 1);
        chk("rst_frame_start", 32'(frame_start), 1);
        chk("rst_pmod", 32'(pmod), 32'h88);
        chk("rst_pmod_pol1", 32'(pmod2), 32'h00);
        rst = 0;
        // two free-running frames
        {n_fs, n_ls, n_hs, n_vs, n_rgb, n_part, n_hs2, n_vs2} = '0;
        first_rgb = -1;
        for (int k = 1; k <= 240; k++) begin
            step;
            n_fs  += int'(frame_start);
            n_ls  += int'(line_start);
            n_hs  += int'(!pmod[7]);
            n_vs  += int'(!pmod[3]);
            n_hs2 += int'(pmod2[7]);
            n_vs2 += int'(pmod2[3]);
            if ({pmod[6:4], pmod[2:0]} == 6'h3F) begin
                n_rgb++;
                if (first_rgb < 0) first_rgb = k;
            end else if ({pmod[6:4], pmod[2:0]} != 6'h00) n_part++;
            if (k == 120) chk("fs_at_120", 32'(frame_start), 1);
            if (k == 37) begin
                chk("x_at_37", 32'(x), 7);
                chk("y_at_37", 32'(y), 2);
                chk("active_at_37", 32'(active), 1);
            end
            if (k == 38) chk("active_at_38", 32'(active), 0);
            if (k == 60) begin
                chk("y_at_60", 32'(y), 4);
                chk("active_at_60", 32'(active), 0);
                chk("ls_at_60", 32'(line_start), 1);
            end
            if (k == 75) chk("fs_at_75", 32'(frame_start), 0);
        end
        chk("frame_start_count", n_fs, 2);
        chk("line_start_count", n_ls, 16);
        chk("hsync_low_count", n_hs, 48);
        chk("vsync_low_count", n_vs, 60);
        chk("rgb_on_count", n_rgb, 64);
        chk("rgb_partial_count", n_part, 0);
        chk("rgb_first_cycle", first_rgb, 2);
        chk("hsync_high_pol1", n_hs2, 48);
        chk("vsync_high_pol1", n_vs2, 60);
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame_cnt_2", 32'(fcnt), 2);
        for (int k = 0; k < 120; k++) step;
        chk("frame_cnt_3", 32'(fcnt), 3);
`endif
        // pix_ce toggling: one line takes twice the clocks, everything holds on idle cycles
        rst = 1;
        step;
        rst = 0;
        for (int i = 0; i < 30; i++) begin
            pix_ce = (i % 2) == 0;
            prev_pmod = pmod;
            prev_x = x;
            step;
            if (!pix_ce) begin
                chk("ce_hold_pmod", 32'(pmod), 32'(prev_pmod));
                chk("ce_hold_x", 32'(x), 32'(prev_x));
            end
        end
        pix_ce = 1;
        chk("ce_line_x", 32'(x), 0);
        chk("ce_line_y", 32'(y), 1);
        chk("ce_line_start", 32'(line_start), 1);
        // reset mid-frame inside both sync pulses
        rst = 1;
        step;
        rst = 0;
        for (int k = 0; k < 87; k++) step;
        chk("mid_x", 32'(x), 12);
        chk("mid_y", 32'(y), 5);
        chk("mid_pmod", 32'(pmod), 32'h00);
        chk("mid_pmod_pol1", 32'(pmod2), 32'h88);
        rgb_in = 6'b100100;
        rst = 1;
        step;
        chk("mrst_x", 32'(x), 0);
        chk("mrst_y", 32'(y), 0);
        chk("mrst_frame_start", 32'(frame_start), 1);
        chk("mrst_pmod", 32'(pmod), 32'h88);
        chk("mrst_pmod_pol1", 32'(pmod2), 32'h00);
        rst = 0;
        step;
        chk("post_rst_pmod", 32'(pmod), 32'h88);
        chk("post_rst_pmod_pol1", 32'(pmod2), 32'h21);
        step;
        chk("pack_a9", 32'(pmod), 32'hA9);
        rgb_in = 6'b011011;
        step;
        chk("pack_de", 32'(pmod), 32'hDE);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
